// File: rtl/mp3_sched_pkg.sv
// mp3_sched_pkg: shared selector type, scheduler states and dec_done/release bit mapping
package mp3_sched_pkg;
  localparam int NSAMP_GRANULE = 576;
  typedef logic [1:0] gc_sel_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STREAM, S_DRAIN, S_NEXT} state_t;
  // buffer {gr,ch}=00 lives on bit 3, 11 on bit 0
  function automatic logic [1:0] gc_bit(input gc_sel_t s);
    return 2'd3 - s;
  endfunction
endpackage

// File: rtl/granule_stream_scheduler_if.sv
// granule_stream_scheduler_if: BRAM read port plus requantizer sample stream
interface granule_stream_scheduler_if #(parameter int ADDR_W = 10, parameter int DATA_W = 16);
  logic              bram_rd_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic [DATA_W-1:0] rq_data;
  logic              rq_valid;
  logic              rq_last;
  logic              rq_ready;
  modport master (output bram_rd_en, bram_addr, rq_data, rq_valid, rq_last, input bram_data, rq_ready);
  modport slave  (input bram_rd_en, bram_addr, rq_data, rq_valid, rq_last, output bram_data, rq_ready);
endinterface

// File: rtl/sched_skid_fifo.sv
// sched_skid_fifo: small circular FIFO that absorbs BRAM read latency
module sched_skid_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign o_data = r_mem[r_rp];
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      o_count <= '0;
    end else begin
      if (i_push) r_wp <= nxt(r_wp);
      if (i_pop) r_rp <= nxt(r_rp);
      o_count <= o_count + CW'(i_push) - CW'(i_pop);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && o_count == CW'(DEPTH)));
endmodule

// File: rtl/granule_stream_scheduler.sv
// granule_stream_scheduler: streams the four granule/channel Huffman buffers into one requantizer.
// Build option GRAN_SCHED_MONO_SKIP_EN: mono frames (mode 2'b11) stream only buffers 00 and 10.
module granule_stream_scheduler
  import mp3_sched_pkg::*;
#(
  parameter int NSAMP  = NSAMP_GRANULE,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_si_valid,
  input  logic [1:0]                i_mode,
  input  logic [3:0]                i_dec_done,
  granule_stream_scheduler_if.master bus,
  output logic                      o_gr,
  output logic                      o_ch,
  output logic [3:0]                o_release,
  output logic                      o_frame_done,
  output logic                      o_overrun
);
  localparam int CW = $clog2(RD_LAT + 2);
  state_t            r_state;
  gc_sel_t           r_sel;
  logic [ADDR_W-1:0] r_addr, r_oidx;
  logic [CW-1:0]     r_cred, w_cnt;
  logic [RD_LAT-1:0] r_vpipe;
  logic [DATA_W-1:0] w_head;
  logic              w_rd, w_acc, w_last, w_mono, w_final;
`ifdef GRAN_SCHED_MONO_SKIP_EN
  logic r_mono;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mono <= 1'b0;
    else if (r_state == S_IDLE && i_si_valid) r_mono <= i_mode == 2'b11;
  assign w_mono = r_mono;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^i_mode;
  assign w_mono = 1'b0;
`endif
  // a credit returned by this cycle's accept may be spent immediately, sustaining 1 sample/cycle
  assign w_acc   = bus.rq_valid && bus.rq_ready;
  assign w_rd    = r_state == S_STREAM && (r_cred != '0 || w_acc);
  assign w_last  = bus.rq_valid && r_oidx == ADDR_W'(NSAMP - 1);
  assign w_final = r_sel == 2'b11 || (w_mono && r_sel == 2'b10);
  assign bus.bram_rd_en = w_rd;
  assign bus.bram_addr  = r_addr;
  assign bus.rq_valid   = w_cnt != '0;
  assign bus.rq_data    = bus.rq_valid ? w_head : '0;
  assign bus.rq_last    = w_last;
  assign o_gr = r_sel[1];
  assign o_ch = r_sel[0];
  sched_skid_fifo #(.DEPTH(RD_LAT + 1), .W(DATA_W)) u_skid (
    .clk, .rst_n,
    .i_push (r_vpipe[RD_LAT-1]),
    .i_data (bus.bram_data),
    .i_pop  (w_acc),
    .o_data (w_head),
    .o_count(w_cnt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_addr       <= '0;
      r_oidx       <= '0;
      r_cred       <= CW'(RD_LAT + 1);
      r_vpipe      <= '0;
      o_release    <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_release    <= '0;
      o_frame_done <= 1'b0;
      if (i_si_valid && r_state != S_IDLE) o_overrun <= 1'b1;
      r_vpipe <= RD_LAT'({r_vpipe, w_rd});
      r_cred  <= r_cred - CW'(w_rd) + CW'(w_acc);
      if (w_rd) r_addr <= r_addr + 1'b1;
      if (w_acc) r_oidx <= w_last ? '0 : r_oidx + 1'b1;
      case (r_state)
        S_IDLE: if (i_si_valid) begin
          r_sel   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (i_dec_done[gc_bit(r_sel)]) begin
          r_addr  <= '0;
          r_state <= S_STREAM;
        end
        S_STREAM: if (w_rd && r_addr == ADDR_W'(NSAMP - 1)) r_state <= S_DRAIN;
        S_DRAIN: if (w_acc && w_last) begin
          o_release <= 4'b1 << gc_bit(r_sel);
          r_state   <= S_NEXT;
        end
        S_NEXT: begin
          r_sel        <= w_mono ? r_sel + 2'd2 : r_sel + 2'd1;
          o_frame_done <= w_final;
          r_state      <= w_final ? S_IDLE : S_WAIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_granule_stream_scheduler.sv
// tb_granule_stream_scheduler: directed frames with random requantizer backpressure,
// checked against a frame-order model of the expected sample stream.
module tb_granule_stream_scheduler;
  localparam int NSAMP = 576, ADDR_W = 10, DATA_W = 16, RD_LAT = 3, CAP = RD_LAT + 1;
`ifdef GRAN_SCHED_MONO_SKIP_EN
  localparam bit MONO_EN = 1'b1;
`else
  localparam bit MONO_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, si_valid = 1'b0;
  logic [1:0] mode = '0;
  logic [3:0] dec_done = '0;
  logic       gr, ch, frame_done, overrun;
  logic [3:0] rel;
  granule_stream_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  granule_stream_scheduler #(.NSAMP(NSAMP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .i_si_valid(si_valid), .i_mode(mode), .i_dec_done(dec_done),
    .bus(bus), .o_gr(gr), .o_ch(ch), .o_release(rel), .o_frame_done(frame_done), .o_overrun(overrun));
  always #5 clk = ~clk;
  function automatic logic [DATA_W-1:0] pat(input int s, input int a);
    return DATA_W'(s * 4096 + a);
  endfunction
  // BRAM bank: the buffer addressed is the one gr/ch selects
  logic [DATA_W-1:0] bram_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) bram_pipe[i] <= bram_pipe[i-1];
    bram_pipe[0] <= bus.bram_rd_en ? pat({gr, ch}, int'(bus.bram_addr)) : 16'hDEAD;
  end
  assign bus.bram_data = bram_pipe[RD_LAT-1];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  int duty = 100, frames_started = 0, frames_aborted = 0;
  bit mono_mode = 1'b0;
  int cyc = 0, m_acc = 0, m_rd = 0, m_k = 0, m_i = 0, m_s = 0, m_fd = 0, m_rel = 0, m_frames = 0;
  int first_cyc = 0, exp_addr = 0;
  logic [3:0] rel_exp = '0, rd_mask = '0;
  bit rel_last = 1'b0, fd_exp = 1'b0, fd_n = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_acc = 0; m_rd = 0; m_k = 0; m_i = 0; exp_addr = 0;
      rel_exp = '0; rel_last = 1'b0; fd_exp = 1'b0; rd_mask = '0;
    end else begin
      chk("release", rel, rel_exp);
      chk("frame_done", frame_done, fd_exp);
      if (frame_done) m_fd++;
      if (rel != '0) m_rel++;
      fd_n = rel_exp != '0 && rel_last;
      rel_exp = '0;
      if (bus.bram_rd_en) begin
        chk("rd_addr", bus.bram_addr, exp_addr);
        exp_addr = exp_addr == NSAMP - 1 ? 0 : exp_addr + 1;
        m_rd++;
        rd_mask[{gr, ch}] = 1'b1;
      end
      if (bus.rq_valid && bus.rq_ready) begin
        m_s = mono_mode ? 2 * m_k : m_k;
        chk("frame_armed", m_frames + frames_aborted < frames_started, 1);
        chk("rq_data", bus.rq_data, pat(m_s, m_i));
        chk("rq_last", bus.rq_last, m_i == NSAMP - 1);
        chk("gr_ch", {gr, ch}, m_s);
        if (m_i == 0) first_cyc = cyc;
        if (m_i == NSAMP - 1 && duty == 100) chk("burst_span", cyc - first_cyc, NSAMP - 1);
        m_acc++;
        m_i++;
        if (m_i == NSAMP) begin
          m_i = 0;
          rel_exp = 4'b1 << (3 - m_s);
          rel_last = m_k == (mono_mode ? 1 : 3);
          m_k = rel_last ? 0 : m_k + 1;
          if (rel_last) m_frames++;
        end
      end
      chk("outstanding", m_rd - m_acc >= 0 && m_rd - m_acc <= CAP, 1);
      fd_exp = fd_n;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    bus.rq_ready = duty >= 100 ? 1'b1 : ($urandom_range(0, 99) < duty);
  endtask
  task automatic start_frame(input logic [1:0] md);
    mode = md;
    mono_mode = MONO_EN && md == 2'b11;
    frames_started++;
    si_valid = 1'b1;
    step();
    si_valid = 1'b0;
  endtask
  task automatic wait_frame(input int fd0, input int lim);
    int n = 0;
    while (m_fd == fd0 && n < lim) begin step(); n++; end
    chk("frame_timeout", m_fd > fd0, 1);
  endtask
  task automatic wait_acc(input int target, input int lim, input string tag);
    int n = 0;
    while (m_acc < target && n < lim) begin step(); n++; end
    chk(tag, m_acc >= target, 1);
  endtask
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, bus.bram_rd_en, 0);
    chk({tag, "_rq_valid"}, bus.rq_valid, 0);
    chk({tag, "_rq_data"}, bus.rq_data, 0);
    chk({tag, "_gr_ch"}, {gr, ch}, 0);
    chk({tag, "_release"}, rel, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask
  int base, fd0, rel0, n;
  initial begin
    bus.rq_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_addr", bus.bram_addr, 0);
    chk("reset_rq_last", bus.rq_last, 0);
    rst_n = 1'b1;
    step();
    // full-rate frame, all buffers ready up front
    dec_done = 4'hF;
    base = m_acc; fd0 = m_fd; rel0 = m_rel;
    start_frame(2'b00);
    n = 0;
    while (!bus.rq_valid && n < 50) begin step(); n++; end
    chk("first_valid_latency", n, RD_LAT + 2);
    wait_frame(fd0, 6000);
    chk("a_accepts", m_acc - base, 4 * NSAMP);
    chk("a_releases", m_rel - rel0, 4);
    // 30% ready duty with buffer 01 decoded late
    duty = 30;
    dec_done = 4'hB;
    base = m_acc; fd0 = m_fd; rel0 = m_rel;
    start_frame(2'b00);
    wait_acc(base + NSAMP, 8000, "b_buf0_timeout");
    step();
    step();
    for (int i = 0; i < 500; i++) begin
      if (i % 50 == 0) begin
        chk("b_wait_gr", gr, 0);
        chk("b_wait_ch", ch, 1);
        chk("b_wait_rd_en", bus.bram_rd_en, 0);
        chk("b_wait_rq_valid", bus.rq_valid, 0);
      end
      step();
    end
    dec_done = 4'hF;
    wait_frame(fd0, 12000);
    chk("b_accepts", m_acc - base, 4 * NSAMP);
    chk("b_releases", m_rel - rel0, 4);
    // side info arriving mid-frame
    duty = 100;
    chk("c_overrun_before", overrun, 0);
    base = m_acc; fd0 = m_fd;
    start_frame(2'b00);
    wait_acc(base + NSAMP + 10, 3000, "c_buf1_timeout");
    si_valid = 1'b1;
    step();
    si_valid = 1'b0;
    step();
    chk("c_overrun_set", overrun, 1);
    wait_frame(fd0, 6000);
    chk("c_accepts", m_acc - base, 4 * NSAMP);
    base = m_acc; fd0 = m_fd;
    start_frame(2'b00);
    wait_frame(fd0, 6000);
    chk("c_second_frame_accepts", m_acc - base, 4 * NSAMP);
    chk("c_overrun_sticky", overrun, 1);
    // asynchronous reset partway through buffer 00
    base = m_acc; rel0 = m_rel;
    start_frame(2'b00);
    wait_acc(base + 300, 1000, "d_acc300_timeout");
    rst_n = 1'b0;
    frames_aborted++;
    #1;
    check_idle_outputs("d_async_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("d_no_release", m_rel - rel0, 0);
    base = m_acc; fd0 = m_fd;
    start_frame(2'b00);
    step();
    chk("d_restart_gr_ch", {gr, ch}, 0);
    wait_frame(fd0, 6000);
    chk("d_restart_accepts", m_acc - base, 4 * NSAMP);
    // mono header: channel 1 buffers skipped only when the option is built in
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    base = m_acc; fd0 = m_fd; rel0 = m_rel;
    start_frame(2'b11);
    wait_frame(fd0, 6000);
    chk("e_accepts", m_acc - base, MONO_EN ? 2 * NSAMP : 4 * NSAMP);
    chk("e_releases", m_rel - rel0, MONO_EN ? 2 : 4);
    chk("e_buffers_read", rd_mask, MONO_EN ? 4'b0101 : 4'b1111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
